// File: rtl/hbuf_rdout_pkg.sv
// ---------------------------------------------------------------------------
// hbuf_rdout_pkg
// Shared definitions for the HBUF readout streamer:
//   - FSM state encoding for the record handshake
//   - number of 16-bit words packed into one 64-bit DPRAM beat
//   - sideband width carried alongside each beat (sop, eop, nwords)
//   - length-to-beats helper
// ---------------------------------------------------------------------------
package hbuf_rdout_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } rdout_state_t;

    localparam int WORDS_PER_BEAT = 4;

    // sop + eop + 2-bit nwords
    localparam int SIDEBAND_W = 4;

    // Number of 64-bit beats needed to carry len 16-bit words.
    function automatic int unsigned len_to_beats(input int unsigned len);
        return (len + WORDS_PER_BEAT - 1) / WORDS_PER_BEAT;
    endfunction

endpackage

// File: rtl/hbuf_rdout_streamer_skid_buf.sv
// ---------------------------------------------------------------------------
// rdout_skid_buf
// Two-entry FIFO-style skid buffer between the DPRAM read port and the
// downstream valid/ready stream. Each entry holds one 64-bit beat plus its
// sop/eop/nwords sideband.
//
// The writer never checks for space: the streamer only issues a DPRAM read
// when the entry it will produce is guaranteed a slot, so push is always
// accepted. The fill level is exported so the streamer can make that call.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write push_data this cycle
//   push_data    {sop, eop, nwords[1:0], data[63:0]}
//   out_ready    downstream ready; pops the head when out_valid
//   out_valid    head entry is valid
//   out_data     head entry (all zero while empty)
//   level        number of occupied entries (0..2)
// ---------------------------------------------------------------------------
module rdout_skid_buf
    import hbuf_rdout_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [DATA_W+SIDEBAND_W-1:0] push_data,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [DATA_W+SIDEBAND_W-1:0] out_data,
    output logic [1:0]                   level
);

    localparam int ENTRY_W = DATA_W + SIDEBAND_W;

    logic [ENTRY_W-1:0] mem [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         count;
    logic               do_pop;

    assign do_pop    = out_ready && (count != 2'd0);
    assign out_valid = (count != 2'd0);
    assign level     = count;
    // Gate the head so every output reads zero while nothing is held.
    assign out_data  = (count != 2'd0) ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/hbuf_rdout_streamer.sv
// ---------------------------------------------------------------------------
// hbuf_rdout_streamer
// Consumer side of the wvb_reader -> HBUF_RDOUT_DPRAM handshake. On a
// dpram_run pulse it owns the DPRAM, reads 64-bit words from address 0
// through port B and streams ceil(len/4) beats downstream with SOP/EOP
// framing, then pulses dpram_done and releases the buffer.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   dpram_run         record-ready pulse from wvb_reader
//   dpram_len         record length in 16-bit words (sampled with run)
//   dpram_mode        record type tag (sampled with run)
//   dpram_busy        record owned by this block
//   dpram_done        1-cycle pulse after the last beat is delivered
//   rd_addr, rd_data  DPRAM port B (1-cycle read latency)
//   out_*             valid/ready stream with sop/eop/nwords/mode
//   len_err           sticky: zero or over-capacity length seen
//   run_while_busy    sticky: dpram_run arrived while busy
// ---------------------------------------------------------------------------
module hbuf_rdout_streamer
    import hbuf_rdout_pkg::*;
#(
    parameter int P_RD_ADR_WIDTH = 9,
    parameter int P_LEN_WIDTH    = 16,
    parameter int P_MAX_WORDS    = 2048
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      dpram_run,
    input  logic [P_LEN_WIDTH-1:0]    dpram_len,
    input  logic                      dpram_mode,
    output logic                      dpram_busy,
    output logic                      dpram_done,
    output logic [P_RD_ADR_WIDTH-1:0] rd_addr,
    input  logic [63:0]               rd_data,
    output logic [63:0]               out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_sop,
    output logic                      out_eop,
    output logic [1:0]                out_nwords,
    output logic                      out_mode,
    output logic                      len_err,
    output logic                      run_while_busy
);

    // One extra bit so a full 512-beat record cannot wrap the counters.
    localparam int BEAT_W = P_RD_ADR_WIDTH + 1;
    localparam logic [BEAT_W-1:0]      ONE_BEAT = BEAT_W'(1);
    localparam logic [P_LEN_WIDTH-1:0] MAX_LEN  = P_LEN_WIDTH'(P_MAX_WORDS);

    rdout_state_t state;
    rdout_state_t state_next;

    // Record parameters latched on acceptance
    logic [BEAT_W-1:0] beats;
    logic [1:0]        last_nw;
    logic              mode_q;
    logic              len_err_q;
    logic              rwb_q;

    // Read issue tracking
    logic [BEAT_W-1:0] issue_cnt;
    logic [BEAT_W-1:0] addr_cnt;
    logic [BEAT_W-1:0] last_addr;
    logic              issue;
    logic [2:0]        occupancy;

    // Decoded run request
    logic                   accept;
    logic                   busy_state;
    logic                   len_zero;
    logic                   len_over;
    logic [P_LEN_WIDTH-1:0] len_eff;
    logic [BEAT_W-1:0]      beats_in;
    logic [1:0]             last_nw_in;

    // Read-data pipeline tag (read issued last cycle, data on rd_data now)
    logic       vld_p1;
    logic       sop_p1;
    logic       eop_p1;
    logic [1:0] nw_p1;

    // Skid buffer interface
    logic                    sk_valid;
    logic [64+SIDEBAND_W-1:0] sk_data;
    logic [64+SIDEBAND_W-1:0] push_data;
    logic [1:0]              sk_level;
    logic                    pop;
    logic                    head_eop;

    assign busy_state = (state == ST_FETCH) || (state == ST_STREAM);
    assign accept     = dpram_run && !busy_state;
    assign len_zero   = (dpram_len == '0);
    assign len_over   = (dpram_len > MAX_LEN);
    assign len_eff    = len_over ? MAX_LEN : dpram_len;
    assign beats_in   = BEAT_W'(len_to_beats(32'(len_eff)));
    assign last_nw_in = 2'(len_eff - P_LEN_WIDTH'(1));
    assign last_addr  = beats - ONE_BEAT;

    assign pop      = sk_valid && out_ready;
    assign head_eop = sk_data[66];

    // -----------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (dpram_run) begin
                    // A zero-length record has nothing to fetch; it only
                    // produces the done pulse.
                    state_next = len_zero ? ST_DONE : ST_FETCH;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_next = ST_STREAM;
            end
            ST_STREAM: begin
                if (pop && head_eop) begin
                    state_next = ST_DONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------
    always_comb begin
        dpram_busy = 1'b0;
        dpram_done = 1'b0;
        unique case (state)
            ST_FETCH, ST_STREAM: dpram_busy = 1'b1;
            ST_DONE:             dpram_done = 1'b1;
            default: begin
                dpram_busy = 1'b0;
                dpram_done = 1'b0;
            end
        endcase
    end

    // A read may be issued only if its data will find a free skid entry
    // next cycle even when nothing is popped then: entries held after this
    // cycle plus the read already in flight must leave one slot.
    always_comb begin
        issue     = 1'b0;
        occupancy = 3'(sk_level) + 3'(vld_p1);
        unique case (state)
            ST_FETCH:  issue = 1'b1;
            ST_STREAM: issue = (issue_cnt < beats) &&
                               (occupancy <= (3'd1 + 3'(pop)));
            default:   issue = 1'b0;
        endcase
    end

    // -----------------------------------------------------------------
    // Stage p0: record control and read-address generation
    // -----------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats     <= '0;
            last_nw   <= 2'd0;
            mode_q    <= 1'b0;
            len_err_q <= 1'b0;
            rwb_q     <= 1'b0;
            issue_cnt <= '0;
            addr_cnt  <= '0;
            vld_p1    <= 1'b0;
        end else begin
            if (accept) begin
                beats     <= beats_in;
                last_nw   <= last_nw_in;
                mode_q    <= dpram_mode;
                issue_cnt <= '0;
                addr_cnt  <= '0;
                if (len_zero || len_over) begin
                    len_err_q <= 1'b1;
                end
            end else if (!busy_state) begin
                issue_cnt <= '0;
                addr_cnt  <= '0;
            end else if (issue) begin
                issue_cnt <= issue_cnt + ONE_BEAT;
                // Park on the last needed address once it has been read.
                if (addr_cnt != last_addr) begin
                    addr_cnt <= addr_cnt + ONE_BEAT;
                end
            end

            if (dpram_run && busy_state) begin
                rwb_q <= 1'b1;
            end

            vld_p1 <= issue;
        end
    end

    // -----------------------------------------------------------------
    // Stage p1: framing tag for the word arriving on rd_data
    // -----------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (issue) begin
            sop_p1 <= (issue_cnt == '0);
            eop_p1 <= (issue_cnt == last_addr);
            nw_p1  <= (issue_cnt == last_addr) ? last_nw : 2'd3;
        end
    end

    assign push_data = {sop_p1, eop_p1, nw_p1, rd_data};

    // -----------------------------------------------------------------
    // Stage p2: skid buffer / output stream
    // -----------------------------------------------------------------
    rdout_skid_buf #(
        .DATA_W (64)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (vld_p1),
        .push_data (push_data),
        .out_ready (out_ready),
        .out_valid (sk_valid),
        .out_data  (sk_data),
        .level     (sk_level)
    );

    assign rd_addr        = addr_cnt[P_RD_ADR_WIDTH-1:0];
    assign out_valid      = sk_valid;
    assign out_data       = sk_data[63:0];
    assign out_sop        = sk_data[67];
    assign out_eop        = sk_data[66];
    assign out_nwords     = sk_data[65:64];
    assign out_mode       = mode_q;
    assign len_err        = len_err_q;
    assign run_while_busy = rwb_q;

endmodule

// File: tb/tb_hbuf_rdout_streamer.sv
// ---------------------------------------------------------------------------
// tb_hbuf_rdout_streamer
// Bench for hbuf_rdout_streamer. A behavioural DPRAM feeds port B; the
// expected stream for a record is derived directly from the DPRAM contents
// and the record length (beat b carries DPRAM word b, sop on the first,
// eop and a partial word count on the last).
// ---------------------------------------------------------------------------
module tb_hbuf_rdout_streamer;

    localparam int MAXW = 2048;

    logic        clk;
    logic        rst_n;
    logic        dpram_run;
    logic [15:0] dpram_len;
    logic        dpram_mode;
    logic        dpram_busy;
    logic        dpram_done;
    logic [8:0]  rd_addr;
    logic [63:0] rd_data;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sop;
    logic        out_eop;
    logic [1:0]  out_nwords;
    logic        out_mode;
    logic        len_err;
    logic        run_while_busy;

    logic [63:0] mem [512];

    int checks   = 0;
    int failures = 0;

    hbuf_rdout_streamer #(
        .P_RD_ADR_WIDTH (9),
        .P_LEN_WIDTH    (16),
        .P_MAX_WORDS    (MAXW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .dpram_run      (dpram_run),
        .dpram_len      (dpram_len),
        .dpram_mode     (dpram_mode),
        .dpram_busy     (dpram_busy),
        .dpram_done     (dpram_done),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_sop        (out_sop),
        .out_eop        (out_eop),
        .out_nwords     (out_nwords),
        .out_mode       (out_mode),
        .len_err        (len_err),
        .run_while_busy (run_while_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DPRAM port B, registered read
    always @(posedge clk) rd_data <= mem[rd_addr];

    typedef struct packed {
        int len;
        bit rnd;
        int beats;
        int last_nw;
        bit err;
        int maxa;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Fill the DPRAM as 256 128-bit writes split little-endian into 64-bit words.
    task automatic fill_mem();
        logic [127:0] w;
        for (int k = 0; k < 256; k++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            mem[2*k]   = w[63:0];
            mem[2*k+1] = w[127:64];
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        dpram_run  = 1'b0;
        out_ready  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Issue one record at the current negedge (cycle 0) and follow it until
    // the done pulse. Returns at the negedge of the done cycle.
    task automatic run_record(input int len, input bit mode, input bit rnd, input int abuse_at,
                              output int nbeats, output int last_nw, output int maxa,
                              output int first_cyc, output int done_cyc, output int eop_cyc,
                              output bit busy_seen, output bit busy_at_done);
        int leff, beats, cyc, limit;
        bit done_seen, prev_stall;
        logic [67:0] prev_beat, cur_beat, exp_beat;
        leff = (len > MAXW) ? MAXW : len;
        beats = (leff + 3) / 4;
        nbeats = 0; last_nw = -1; maxa = 0; first_cyc = -1; done_cyc = -1; eop_cyc = -1;
        busy_seen = 1'b0; busy_at_done = 1'b0;
        done_seen = 1'b0; prev_stall = 1'b0; prev_beat = '0;
        limit = 20 + beats * 40;
        dpram_len  = 16'(len);
        dpram_mode = mode;
        dpram_run  = 1'b1;
        out_ready  = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (!done_seen && cyc < limit) begin
            if (cyc == abuse_at) begin
                dpram_run  = 1'b1;
                dpram_len  = 16'd8;
                dpram_mode = ~mode;
            end else begin
                dpram_run = 1'b0;
            end
            if (dpram_busy) busy_seen = 1'b1;
            if (int'(rd_addr) > maxa) maxa = int'(rd_addr);
            cur_beat = {out_sop, out_eop, out_nwords, out_data};
            if (prev_stall) check("stall_hold", {out_valid, cur_beat}, {1'b1, prev_beat});
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                check("out_mode", out_mode, mode);
                if (out_ready) begin
                    if (nbeats >= beats) begin
                        check("extra_beat", nbeats, beats - 1);
                    end else begin
                        exp_beat = {nbeats == 0, nbeats == beats - 1,
                                    (nbeats == beats - 1) ? 2'(leff - 1) : 2'd3, mem[nbeats]};
                        check($sformatf("beat%0d", nbeats), cur_beat, exp_beat);
                    end
                    if (out_eop) begin
                        eop_cyc = cyc;
                        last_nw = int'(out_nwords);
                    end
                    nbeats++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_beat  = cur_beat;
            if (dpram_done) begin
                done_seen    = 1'b1;
                done_cyc     = cyc;
                busy_at_done = dpram_busy;
            end
            if (!done_seen) begin
                @(negedge clk);
                cyc++;
            end
        end
        dpram_run = 1'b0;
        if (!done_seen) check("done_timeout", 0, 1);
    endtask

    int  nb, lnw, ma, fc, dc, ec, leff, eb;
    bit  bs, bad;
    bit  exp_err;
    int  rlen;

    initial begin
        rst_n      = 1'b0;
        dpram_run  = 1'b0;
        dpram_len  = '0;
        dpram_mode = 1'b0;
        out_ready  = 1'b0;

        //           len   rnd beats nw err maxa
        vecs[0] = '{16,   1'b0,   4, 3, 1'b0,   3};
        vecs[1] = '{1026, 1'b0, 257, 1, 1'b0, 256};
        vecs[2] = '{64,   1'b1,  16, 3, 1'b0,  15};
        vecs[3] = '{0,    1'b0,   0, 0, 1'b1,   0};
        vecs[4] = '{4096, 1'b0, 512, 3, 1'b1, 511};
        vecs[5] = '{2048, 1'b0, 512, 3, 1'b0, 511};
        vecs[6] = '{5,    1'b1,   2, 0, 1'b0,   1};
        vecs[7] = '{3,    1'b0,   1, 2, 1'b0,   0};
        vecs[8] = '{7,    1'b1,   2, 2, 1'b0,   1};

        fill_mem();
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_ctrl", {dpram_busy, dpram_done, out_valid, out_sop, out_eop, out_nwords,
                           out_mode, len_err, run_while_busy}, '0);
        check("rst_addr", rd_addr, 0);
        check("rst_data", out_data, 0);
        rst_n = 1'b1;

        // Table-driven records
        for (int i = 0; i < NV; i++) begin
            apply_reset();
            fill_mem();
            run_record(vecs[i].len, bit'(i % 2), vecs[i].rnd, -1, nb, lnw, ma, fc, dc, ec, bs, bad);
            check($sformatf("v%0d_beats", i), nb, vecs[i].beats);
            if (vecs[i].beats > 0) begin
                check($sformatf("v%0d_last_nw", i), lnw, vecs[i].last_nw);
                check($sformatf("v%0d_max_addr", i), ma, vecs[i].maxa);
                check($sformatf("v%0d_first_valid", i), fc, 3);
                check($sformatf("v%0d_done_after_eop", i), dc, ec + 1);
                check($sformatf("v%0d_busy_seen", i), bs, 1);
            end else begin
                check($sformatf("v%0d_done_cycle", i), dc, 1);
                check($sformatf("v%0d_busy_seen", i), bs, 0);
            end
            check($sformatf("v%0d_busy_at_done", i), bad, 0);
            check($sformatf("v%0d_len_err", i), len_err, vecs[i].err);
            @(negedge clk);
            check($sformatf("v%0d_idle", i), {dpram_busy, dpram_done, out_valid, rd_addr}, '0);
        end

        // Back-to-back: second run issued in the DONE cycle
        apply_reset();
        fill_mem();
        run_record(16, 1'b0, 1'b0, -1, nb, lnw, ma, fc, dc, ec, bs, bad);
        check("b2b_first_beats", nb, 4);
        run_record(8, 1'b1, 1'b0, -1, nb, lnw, ma, fc, dc, ec, bs, bad);
        check("b2b_second_beats", nb, 2);
        check("b2b_second_sop_lat", fc, 3);
        check("b2b_rwb", run_while_busy, 0);

        // Second run mid-stream is ignored
        apply_reset();
        fill_mem();
        run_record(64, 1'b1, 1'b1, 6, nb, lnw, ma, fc, dc, ec, bs, bad);
        check("abuse_beats", nb, 16);
        check("abuse_rwb", run_while_busy, 1);
        @(negedge clk);
        @(negedge clk);
        check("abuse_no_restart", {dpram_busy, out_valid}, '0);

        // Reset pulsed mid-record
        apply_reset();
        fill_mem();
        dpram_len  = 16'd64;
        dpram_mode = 1'b1;
        dpram_run  = 1'b1;
        out_ready  = 1'b1;
        @(negedge clk);
        dpram_run = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_outputs", {dpram_busy, dpram_done, out_valid, out_sop, out_eop, out_nwords,
                                  out_mode, rd_addr, out_data}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        run_record(16, 1'b0, 1'b0, -1, nb, lnw, ma, fc, dc, ec, bs, bad);
        check("post_rst_beats", nb, 4);
        check("post_rst_first_valid", fc, 3);

        // Randomized records against the length model, len_err tracked as sticky
        apply_reset();
        exp_err = 1'b0;
        for (int r = 0; r < 6; r++) begin
            fill_mem();
            rlen = (r == 0) ? 0 : int'($urandom_range(1, 2100));
            leff = (rlen > MAXW) ? MAXW : rlen;
            eb   = (leff + 3) / 4;
            if (rlen == 0 || rlen > MAXW) exp_err = 1'b1;
            run_record(rlen, bit'($urandom_range(0, 1)), 1'b1, -1, nb, lnw, ma, fc, dc, ec, bs, bad);
            check($sformatf("rnd%0d_beats", r), nb, eb);
            if (eb > 0) begin
                check($sformatf("rnd%0d_max_addr", r), ma, eb - 1);
                check($sformatf("rnd%0d_last_nw", r), lnw, (leff - 1) % 4);
            end
            check($sformatf("rnd%0d_len_err", r), len_err, exp_err);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
